// File: rtl/plotfour_pkg.sv
// Shared definitions for the plot-four game logic: board geometry, player
// identifiers, turn-controller state encoding and the table of winning lines.
package plotfour_pkg;

    localparam int NUM_SQ    = 20;
    localparam int NUM_COLS  = 4;
    localparam int NUM_ROWS  = 5;
    localparam int NUM_LINES = 17;

    localparam logic P_ONE = 1'b0;
    localparam logic P_TWO = 1'b1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WAIT   = 3'd1,
        COMMIT = 3'd2,
        CHECK  = 3'd3,
        OVER   = 3'd4
    } state_t;

    // Every set of four squares that forms a line on the 4x5 board
    // (square index = row*4 + col).
    localparam logic [NUM_SQ-1:0] WIN_LINES [NUM_LINES] = '{
        // horizontal rows 0..4
        20'h0000F, 20'h000F0, 20'h00F00, 20'h0F000, 20'hF0000,
        // vertical, rows 0-3, columns 0..3
        20'h01111, 20'h02222, 20'h04444, 20'h08888,
        // vertical, rows 1-4, columns 0..3
        20'h11110, 20'h22220, 20'h44440, 20'h88880,
        // down-right diagonals from squares 0 and 4
        20'h08421, 20'h84210,
        // down-left diagonals from squares 3 and 7
        20'h01248, 20'h12480
    };

    // One-hot mask of a square; all zeros when the square is off the board.
    function automatic logic [NUM_SQ-1:0] sq_onehot(input logic [5:0] sq);
        logic [NUM_SQ-1:0] mask;
        mask = '0;
        if (sq < 6'(NUM_SQ)) begin
            mask = {{(NUM_SQ-1){1'b0}}, 1'b1} << sq[4:0];
        end
        return mask;
    endfunction

endpackage

// File: rtl/plotfour_win_check.sv
// Combinational line detector: reports whether one player's occupancy
// register covers any of the winning lines.
module plotfour_win_check
    import plotfour_pkg::*;
(
    input  logic [NUM_SQ-1:0] board,
    output logic              win
);

    // OR over all lines that are completely covered by the board.
    always_comb begin
        win = 1'b0;
        for (int i = 0; i < NUM_LINES; i++) begin
            if ((board & WIN_LINES[i]) == WIN_LINES[i]) begin
                win = 1'b1;
            end
        end
    end

endmodule

// File: rtl/plotfour_turn_ctrl.sv
// Turn controller for one game of plot-four: detects key presses, takes the
// request of the player whose turn it is, validates and commits the square,
// then evaluates win/draw on the updated board. Optional per-turn timeout.
module plotfour_turn_ctrl
    import plotfour_pkg::*;
#(
    parameter logic        FIRST_PLAYER = P_ONE,
    parameter int unsigned TURN_TIMEOUT = 0
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic              start,
    input  logic              p_one_req,
    input  logic              p_two_req,
    input  logic [5:0]        square,
    output logic [NUM_SQ-1:0] blue,
    output logic [NUM_SQ-1:0] red,
    output logic              turn,
    output logic              p_one_win,
    output logic              p_two_win,
    output logic              draw,
    output logic              move_ok,
    output logic              move_rej,
    output logic [4:0]        last_sq
);

    localparam logic        TIMER_EN   = (TURN_TIMEOUT != 0);
    localparam logic [31:0] TIMER_LAST = TURN_TIMEOUT - 32'd1;

    state_t state, state_nxt;

    logic              p_one_req_q, p_two_req_q;
    logic              p_one_edge, p_two_edge, turn_edge;
    logic [5:0]        sq_lat;
    logic [NUM_SQ-1:0] sq_bit, occupied, mover_board;
    logic              sq_bad, mover_wins, board_full, timeout_hit;
    logic [31:0]       timer;

    // Control strobes produced by the next-state logic
    logic do_start, do_take, do_commit, do_reject;
    logic do_win, do_draw, do_next, do_timeout, do_tick;

    assign p_one_edge  = p_one_req & ~p_one_req_q;
    assign p_two_edge  = p_two_req & ~p_two_req_q;
    // Only the player to move can open a transaction; the other key is ignored.
    assign turn_edge   = (turn == P_TWO) ? p_two_edge : p_one_edge;

    assign occupied    = blue | red;
    assign sq_bit      = sq_onehot(sq_lat);
    assign sq_bad      = (sq_bit == '0) || ((sq_bit & occupied) != '0);
    assign board_full  = &occupied;
    assign timeout_hit = TIMER_EN && (timer == TIMER_LAST);

    // Only the mover can have completed a line, so only its register is checked.
    assign mover_board = (turn == P_TWO) ? red : blue;

    plotfour_win_check u_win_check (
        .board (mover_board),
        .win   (mover_wins)
    );

    // State register.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode; dropping start overrides every state.
    always_comb begin
        state_nxt  = state;
        do_start   = 1'b0;
        do_take    = 1'b0;
        do_commit  = 1'b0;
        do_reject  = 1'b0;
        do_win     = 1'b0;
        do_draw    = 1'b0;
        do_next    = 1'b0;
        do_timeout = 1'b0;
        do_tick    = 1'b0;
        if (!start) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    do_start  = 1'b1;
                    state_nxt = WAIT;
                end
                WAIT: begin
                    if (turn_edge) begin
                        do_take   = 1'b1;
                        state_nxt = COMMIT;
                    end else if (timeout_hit) begin
                        do_timeout = 1'b1;
                    end else begin
                        do_tick = TIMER_EN;
                    end
                end
                COMMIT: begin
                    if (sq_bad) begin
                        do_reject = 1'b1;
                        state_nxt = WAIT;
                    end else begin
                        do_commit = 1'b1;
                        state_nxt = CHECK;
                    end
                end
                CHECK: begin
                    if (mover_wins) begin
                        do_win    = 1'b1;
                        state_nxt = OVER;
                    end else if (board_full) begin
                        do_draw   = 1'b1;
                        state_nxt = OVER;
                    end else begin
                        do_next   = 1'b1;
                        state_nxt = WAIT;
                    end
                end
                OVER: begin
                    state_nxt = OVER;
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    // Previous key levels for rising-edge detection.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            p_one_req_q <= 1'b0;
            p_two_req_q <= 1'b0;
        end else begin
            p_one_req_q <= p_one_req;
            p_two_req_q <= p_two_req;
        end
    end

    // Board, flags, pulses and timer, updated from the decoded strobes.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            blue      <= '0;
            red       <= '0;
            turn      <= FIRST_PLAYER;
            p_one_win <= 1'b0;
            p_two_win <= 1'b0;
            draw      <= 1'b0;
            move_ok   <= 1'b0;
            move_rej  <= 1'b0;
            last_sq   <= '0;
            sq_lat    <= '0;
            timer     <= '0;
        end else begin
            move_ok  <= do_commit;
            move_rej <= do_reject;
            if (do_start) begin
                blue      <= '0;
                red       <= '0;
                p_one_win <= 1'b0;
                p_two_win <= 1'b0;
                draw      <= 1'b0;
                timer     <= '0;
                turn      <= FIRST_PLAYER;
            end
            if (do_take) begin
                sq_lat <= square;
            end
            if (do_commit) begin
                if (turn == P_TWO) begin
                    red <= red | sq_bit;
                end else begin
                    blue <= blue | sq_bit;
                end
                last_sq <= sq_lat[4:0];
            end
            if (do_win) begin
                if (turn == P_TWO) begin
                    p_two_win <= 1'b1;
                end else begin
                    p_one_win <= 1'b1;
                end
            end
            if (do_draw) begin
                draw <= 1'b1;
            end
            if (do_next || do_timeout) begin
                turn  <= ~turn;
                timer <= '0;
            end
            if (do_tick) begin
                timer <= timer + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_plotfour_turn_ctrl.sv
// Directed and randomized bench for plotfour_turn_ctrl against a square-by-square
// game model (owner per square, line search by row/column geometry).
module tb_plotfour_turn_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, start, start_t, p_one_req, p_two_req;
    logic [5:0]  square;
    logic [19:0] blue, red, blue_t, red_t;
    logic        turn, p_one_win, p_two_win, draw, move_ok, move_rej;
    logic        turn_t, p_one_win_t, p_two_win_t, draw_t, move_ok_t, move_rej_t;
    logic [4:0]  last_sq, last_sq_t;

    plotfour_turn_ctrl dut (
        .CLOCK_50 (clk), .reset (reset), .start (start),
        .p_one_req (p_one_req), .p_two_req (p_two_req), .square (square),
        .blue (blue), .red (red), .turn (turn),
        .p_one_win (p_one_win), .p_two_win (p_two_win), .draw (draw),
        .move_ok (move_ok), .move_rej (move_rej), .last_sq (last_sq)
    );

    plotfour_turn_ctrl #(.FIRST_PLAYER (1'b1), .TURN_TIMEOUT (8)) dut_t (
        .CLOCK_50 (clk), .reset (reset), .start (start_t),
        .p_one_req (p_one_req), .p_two_req (p_two_req), .square (square),
        .blue (blue_t), .red (red_t), .turn (turn_t),
        .p_one_win (p_one_win_t), .p_two_win (p_two_win_t), .draw (draw_t),
        .move_ok (move_ok_t), .move_rej (move_rej_t), .last_sq (last_sq_t)
    );

    int vectors = 0;
    int fails   = 0;

    // Game model: owner of each square (0 empty, 1 p_one, 2 p_two)
    int       own [20];
    bit       m_turn, m_p1w, m_p2w, m_draw, m_ok, m_rej, m_over;
    bit [4:0] m_last;

    function automatic bit owns(int who, int row, int col);
        return own[row*4 + col] == who;
    endfunction

    function automatic bit model_win(int who);
        bit w = 0;
        for (int r = 0; r < 5; r++)
            if (owns(who, r, 0) && owns(who, r, 1) && owns(who, r, 2) && owns(who, r, 3)) w = 1;
        for (int c = 0; c < 4; c++)
            for (int r0 = 0; r0 < 2; r0++)
                if (owns(who, r0, c) && owns(who, r0+1, c) && owns(who, r0+2, c) && owns(who, r0+3, c)) w = 1;
        for (int r0 = 0; r0 < 2; r0++) begin
            if (owns(who, r0, 0) && owns(who, r0+1, 1) && owns(who, r0+2, 2) && owns(who, r0+3, 3)) w = 1;
            if (owns(who, r0, 3) && owns(who, r0+1, 2) && owns(who, r0+2, 1) && owns(who, r0+3, 0)) w = 1;
        end
        return w;
    endfunction

    function automatic bit model_full();
        bit f = 1;
        for (int i = 0; i < 20; i++) if (own[i] == 0) f = 0;
        return f;
    endfunction

    function automatic logic [19:0] own_mask(int who);
        logic [19:0] m = '0;
        for (int i = 0; i < 20; i++) if (own[i] == who) m[i] = 1'b1;
        return m;
    endfunction

    function automatic logic [63:0] model_vec();
        return 64'({own_mask(1), own_mask(2), m_turn, m_p1w, m_p2w, m_draw, m_ok, m_rej, m_last});
    endfunction

    function automatic logic [63:0] dut_vec();
        return 64'({blue, red, turn, p_one_win, p_two_win, draw, move_ok, move_rej, last_sq});
    endfunction

    task automatic model_new_game(input bit first);
        for (int i = 0; i < 20; i++) own[i] = 0;
        m_turn = first; m_p1w = 0; m_p2w = 0; m_draw = 0;
        m_ok = 0; m_rej = 0; m_over = 0;
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk(tag, dut_vec(), model_vec());
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic restart();
        start = 1'b0;
        tick();
        start = 1'b1;
        tick();
        model_new_game(1'b0);
        check_all("restart");
    endtask

    // One request pulse from either or both keys, checked at the pulse and
    // at the win/draw/turn update.
    task automatic attempt(input bit r1, input bit r2, input int sq);
        bit in_turn, took;
        int mover;
        mover   = m_turn;
        in_turn = !m_over && ((mover == 0) ? r1 : r2);
        took    = 0;
        square    = 6'(sq);
        p_one_req = r1;
        p_two_req = r2;
        tick();
        p_one_req = 1'b0;
        p_two_req = 1'b0;
        if (in_turn) begin
            if (sq >= 20) m_rej = 1;
            else if (own[sq] != 0) m_rej = 1;
            else begin
                own[sq] = mover + 1;
                m_last  = 5'(sq);
                m_ok    = 1;
                took    = 1;
            end
        end
        tick();
        check_all("commit");
        m_ok = 0;
        m_rej = 0;
        if (took) begin
            if (model_win(mover + 1)) begin
                if (mover == 1) m_p2w = 1; else m_p1w = 1;
                m_over = 1;
            end else if (model_full()) begin
                m_draw = 1;
                m_over = 1;
            end else begin
                m_turn = ~m_turn;
            end
        end
        tick();
        check_all("check");
    endtask

    initial begin
        int pulses;
        int blue_sq [10];
        int red_sq  [10];
        blue_sq = '{0, 1, 6, 7, 8, 9, 14, 15, 16, 17};
        red_sq  = '{2, 3, 4, 5, 10, 11, 12, 13, 18, 19};

        reset = 1'b1; start = 1'b0; start_t = 1'b0;
        p_one_req = 1'b0; p_two_req = 1'b0; square = '0;
        model_new_game(1'b0);
        m_last = '0;
        repeat (2) tick();
        check_all("reset");
        chk("reset turn_t", 64'(turn_t), 64'd1);

        // 1: start, first move by p_one
        reset = 1'b0;
        start = 1'b1;
        tick();
        model_new_game(1'b0);
        check_all("start");
        attempt(1, 0, 5);
        chk("blue sq5", 64'(blue), 64'h00020);

        // 2: held key gives one commit; out-of-turn and simultaneous keys
        square = 6'd6;
        p_two_req = 1'b1;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (move_ok) pulses++;
        end
        p_two_req = 1'b0;
        own[6] = 2; m_last = 5'd6; m_turn = 0;
        tick();
        chk("hold pulses", 64'(pulses), 64'd1);
        check_all("hold");
        chk("red sq6", 64'(red), 64'h00040);
        attempt(1, 0, 0);
        attempt(1, 0, 9);
        attempt(1, 1, 10);

        // 3: rejects leave turn and board unchanged
        attempt(1, 0, 5);
        attempt(1, 0, 20);
        attempt(1, 0, 63);

        // 4: diagonal, row and column wins
        restart();
        attempt(1, 0, 0);  attempt(0, 1, 1);
        attempt(1, 0, 5);  attempt(0, 1, 2);
        attempt(1, 0, 10); attempt(0, 1, 3);
        attempt(1, 0, 15);
        chk("diag win", 64'(p_one_win), 64'd1);
        attempt(0, 1, 4);
        attempt(1, 0, 6);
        restart();
        attempt(1, 0, 16); attempt(0, 1, 0);
        attempt(1, 0, 17); attempt(0, 1, 1);
        attempt(1, 0, 18); attempt(0, 1, 2);
        attempt(1, 0, 19);
        chk("row win", 64'(p_one_win), 64'd1);
        restart();
        attempt(1, 0, 0);  attempt(0, 1, 1);
        attempt(1, 0, 2);  attempt(0, 1, 5);
        attempt(1, 0, 3);  attempt(0, 1, 9);
        attempt(1, 0, 6);  attempt(0, 1, 13);
        chk("col win", 64'({p_one_win, p_two_win}), 64'b01);

        // 5: full board with no line is a draw
        restart();
        for (int i = 0; i < 10; i++) begin
            attempt(1, 0, blue_sq[i]);
            attempt(0, 1, red_sq[i]);
        end
        chk("draw", 64'({draw, p_one_win, p_two_win}), 64'b100);

        // 6: turn timeout, stop/restart and asynchronous reset
        start_t = 1'b0;
        restart();
        start_t = 1'b1;
        tick();
        for (int k = 1; k <= 24; k++) begin
            tick();
            chk("timer turn", 64'(turn_t), 64'(1 ^ ((k / 8) % 2)));
            chk("no timer turn", 64'(turn), 64'd0);
        end
        chk("timer outs", 64'({blue_t, red_t, p_one_win_t, p_two_win_t, draw_t, move_ok_t, move_rej_t, last_sq_t}), 64'd0);
        attempt(1, 0, 9);
        start = 1'b0;
        tick();
        check_all("stop keeps board");
        tick();
        check_all("idle keeps board");
        start = 1'b1;
        tick();
        model_new_game(1'b0);
        check_all("restart clears");

        square = 6'd3;
        p_one_req = 1'b1;
        tick();
        p_one_req = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        model_new_game(1'b0);
        m_last = '0;
        check_all("async reset");
        chk("async reset turn_t", 64'(turn_t), 64'd1);
        tick();
        reset = 1'b0;
        tick();
        model_new_game(1'b0);
        check_all("after reset");

        // Randomized games
        for (int g = 0; g < 20; g++) begin
            int after_over;
            restart();
            after_over = 0;
            for (int m = 0; m < 45 && after_over < 2; m++) begin
                int r, sq;
                bit r1, r2;
                r  = int'($urandom_range(0, 9));
                sq = int'($urandom_range(0, 19));
                r1 = (m_turn == 0);
                r2 = (m_turn == 1);
                if (r == 7) begin r1 = ~r1; r2 = ~r2; end
                else if (r == 8) begin r1 = 1; r2 = 1; end
                else if (r == 9) sq = int'($urandom_range(20, 63));
                attempt(r1, r2, sq);
                if (m_over) after_over++;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
